// File: rtl/esc_pkg.sv
// Shared types and defaults for the ESC arm/run/disarm sequencer.
package esc_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_RUN      = 2'd2,
    ST_FAILSAFE = 2'd3
  } esc_state_e;

  localparam int unsigned SPEED_W          = 16;
  localparam int unsigned DEF_FRAME_CYCLES = 100000;
  localparam int unsigned DEF_MAX_CMD      = 45000;

  // Unsigned ceiling clamp of a commanded speed.
  function automatic logic [SPEED_W-1:0] clamp_speed(input logic [SPEED_W-1:0] cmd,
                                                     input logic [SPEED_W-1:0] ceil);
    return (cmd > ceil) ? ceil : cmd;
  endfunction

endpackage

// File: rtl/esc_slew_channel.sv
// One motor channel: clamped target register and per-frame slew-limited speed.
module esc_slew_channel
  import esc_pkg::*;
#(
  parameter int unsigned SLEW_STEP = 500,
  parameter int unsigned MAX_CMD   = DEF_MAX_CMD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SPEED_W-1:0] i_cmd,
  input  logic               i_load,
  input  logic               i_clr,
  input  logic               i_step,
  input  logic               i_zero,
  output logic [SPEED_W-1:0] o_speed,
  output logic               o_step_zero_c
);

  localparam int unsigned        CALC_W = SPEED_W + 1;
  localparam logic [CALC_W-1:0]  STEP   = CALC_W'(SLEW_STEP);
  localparam logic [SPEED_W-1:0] CEIL   = SPEED_W'(MAX_CMD);

  logic [SPEED_W-1:0] r_tgt;
  logic [SPEED_W-1:0] r_cur;
  logic [SPEED_W-1:0] w_step_val;
  logic [CALC_W-1:0]  w_cur_x;
  logic [CALC_W-1:0]  w_tgt_x;
  logic [CALC_W-1:0]  w_up_gap;
  logic [CALC_W-1:0]  w_dn_gap;
  logic [CALC_W-1:0]  w_next_x;

  // Move toward the target by at most STEP; landing exactly on it otherwise.
  always_comb begin
    w_cur_x  = {1'b0, r_cur};
    w_tgt_x  = {1'b0, r_tgt};
    w_up_gap = w_tgt_x - w_cur_x;
    w_dn_gap = w_cur_x - w_tgt_x;
    w_next_x = w_cur_x;
    if (w_cur_x < w_tgt_x) begin
      w_next_x = (w_up_gap > STEP) ? (w_cur_x + STEP) : w_tgt_x;
    end else if (w_cur_x > w_tgt_x) begin
      w_next_x = (w_dn_gap > STEP) ? (w_cur_x - STEP) : w_tgt_x;
    end
    w_step_val = SPEED_W'(w_next_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgt <= '0;
      r_cur <= '0;
    end else begin
      if (i_clr) begin
        r_tgt <= '0;
      end else if (i_load) begin
        r_tgt <= clamp_speed(i_cmd, CEIL);
      end
      if (i_zero) begin
        r_cur <= '0;
      end else if (i_step) begin
        r_cur <= w_step_val;
      end
    end
  end

  assign o_speed       = r_cur;
  assign o_step_zero_c = (w_step_val == '0);

endmodule

// File: rtl/esc_sequencer.sv
// Frame scheduler and arm/run/failsafe sequencer feeding NUM_MOTORS PWM blocks.
module esc_sequencer
  import esc_pkg::*;
#(
  parameter int unsigned NUM_MOTORS     = 4,
  parameter int unsigned FRAME_CYCLES   = DEF_FRAME_CYCLES,
  parameter int unsigned ARM_FRAMES     = 1000,
  parameter int unsigned TIMEOUT_FRAMES = 50,
  parameter int unsigned SLEW_STEP      = 500,
  parameter int unsigned MAX_CMD        = DEF_MAX_CMD
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arm_req,
  input  logic                          disarm_req,
  input  logic                          cmd_valid,
  input  logic [SPEED_W*NUM_MOTORS-1:0] cmd_speed,
  output logic [SPEED_W*NUM_MOTORS-1:0] speed_out,
  output logic                          speed_oe,
  output logic                          armed,
  output logic [1:0]                    state,
  output logic                          fault
);

  localparam int unsigned FRAME_W = $clog2(FRAME_CYCLES);
  localparam int unsigned ARM_W   = $clog2(ARM_FRAMES) + 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_FRAMES) + 1;

  logic [FRAME_W-1:0]    r_frame_cnt;
  logic [ARM_W-1:0]      r_arm_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  esc_state_e            r_state;
  esc_state_e            w_next;
  logic                  r_oe;
  logic                  r_armed;
  logic                  r_fault;
  logic                  w_tick;
  logic                  w_set_fault;
  logic                  w_clr_tgt;
  logic                  w_load_tgt;
  logic                  w_step;
  logic [NUM_MOTORS-1:0] w_ch_zero;
  logic                  w_all_zero;

  assign w_tick     = (r_frame_cnt == FRAME_W'(FRAME_CYCLES - 1));
  assign w_all_zero = &w_ch_zero;

  always_comb begin
    w_next      = r_state;
    w_set_fault = 1'b0;
    if (disarm_req) begin
      w_next = ST_DISARMED;
    end else begin
      unique case (r_state)
        ST_DISARMED: begin
          if (arm_req && !r_fault) w_next = ST_ARMING;
        end
        ST_ARMING: begin
          if (!arm_req) begin
            w_next = ST_DISARMED;
          end else if (w_tick && (r_arm_cnt == ARM_W'(ARM_FRAMES - 1))) begin
            w_next = ST_RUN;
          end
        end
        ST_RUN: begin
          // A command in the final idle frame keeps the link alive.
          if (w_tick && !cmd_valid && (r_to_cnt == TO_W'(TIMEOUT_FRAMES - 1))) begin
            w_next      = ST_FAILSAFE;
            w_set_fault = 1'b1;
          end else if (!arm_req) begin
            w_next = ST_FAILSAFE;
          end
        end
        ST_FAILSAFE: begin
          if (w_tick && w_all_zero) w_next = ST_DISARMED;
        end
        default: w_next = ST_DISARMED;
      endcase
    end
  end

  // Targets read zero throughout FAILSAFE and are wiped on each entry to DISARMED.
  assign w_clr_tgt  = (w_next == ST_FAILSAFE) ||
                      ((w_next == ST_DISARMED) && (r_state != ST_DISARMED));
  assign w_load_tgt = cmd_valid && (r_state != ST_FAILSAFE);
  assign w_step     = w_tick && ((r_state == ST_RUN) || (r_state == ST_FAILSAFE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_arm_cnt   <= '0;
      r_to_cnt    <= '0;
      r_state     <= ST_DISARMED;
      r_oe        <= 1'b0;
      r_armed     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_frame_cnt <= w_tick ? '0 : (r_frame_cnt + FRAME_W'(1));
      r_oe        <= w_tick;
      r_state     <= w_next;
      r_armed     <= (w_next == ST_RUN);
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end else if ((r_state == ST_DISARMED) && !arm_req) begin
        r_fault <= 1'b0;
      end
      if (w_next != ST_ARMING) begin
        r_arm_cnt <= '0;
      end else if (w_tick && (r_state == ST_ARMING)) begin
        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
      if ((w_next != ST_RUN) || cmd_valid) begin
        r_to_cnt <= '0;
      end else if (w_tick && (r_state == ST_RUN)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
    esc_slew_channel #(
      .SLEW_STEP (SLEW_STEP),
      .MAX_CMD   (MAX_CMD)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cmd         (cmd_speed[g*SPEED_W +: SPEED_W]),
      .i_load        (w_load_tgt),
      .i_clr         (w_clr_tgt),
      .i_step        (w_step),
      .i_zero        (disarm_req),
      .o_speed       (speed_out[g*SPEED_W +: SPEED_W]),
      .o_step_zero_c (w_ch_zero[g])
    );
  end

  assign speed_oe = r_oe;
  assign armed    = r_armed;
  assign fault    = r_fault;
  assign state    = r_state;

endmodule

// File: tb/tb_esc_sequencer.sv
// Bench for esc_sequencer: directed arm/slew/timeout/disarm/reset scenarios plus random traffic.
module tb_esc_sequencer;

  localparam int NM = 4;
  localparam int FC = 10;
  localparam int AF = 3;
  localparam int TF = 4;
  localparam int SS = 100;
  localparam int MC = 45000;
  localparam int S_DIS = 0;
  localparam int S_ARM = 1;
  localparam int S_RUN = 2;
  localparam int S_FS  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_req;
  logic        disarm_req;
  logic        cmd_valid;
  logic [63:0] cmd_speed;
  logic [63:0] speed_out;
  logic        speed_oe;
  logic        armed;
  logic [1:0]  state;
  logic        fault;

  esc_sequencer #(
    .NUM_MOTORS(NM), .FRAME_CYCLES(FC), .ARM_FRAMES(AF),
    .TIMEOUT_FRAMES(TF), .SLEW_STEP(SS), .MAX_CMD(MC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm_req(arm_req), .disarm_req(disarm_req),
    .cmd_valid(cmd_valid), .cmd_speed(cmd_speed), .speed_out(speed_out),
    .speed_oe(speed_oe), .armed(armed), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc;

  // Reference model: frame phase, frames seen in ARMING, idle frames in RUN.
  int m_state, m_phase, m_arm_frames, m_idle;
  int m_tgt[NM];
  int m_cur[NM];
  bit m_oe, m_fault;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int slew_to(input int cur, input int tgt);
    if (tgt > cur) return cur + imin(SS, tgt - cur);
    if (tgt < cur) return cur - imin(SS, cur - tgt);
    return cur;
  endfunction

  function automatic int ch_of(input logic [63:0] bus, input int i);
    return int'(bus[16*i +: 16]);
  endfunction

  task automatic model_reset();
    m_state = S_DIS; m_phase = 0; m_arm_frames = 0; m_idle = 0;
    m_oe = 1'b0; m_fault = 1'b0;
    for (int i = 0; i < NM; i++) begin
      m_tgt[i] = 0;
      m_cur[i] = 0;
    end
  endtask

  task automatic model_step(input bit arm, input bit dis, input bit cv, input logic [63:0] cmd);
    bit tick;
    bit all_zero;
    int nxt;
    tick    = (m_phase == FC - 1);
    m_phase = tick ? 0 : m_phase + 1;
    m_oe    = tick;
    nxt     = m_state;
    if (dis) begin
      nxt = S_DIS;
      for (int i = 0; i < NM; i++) m_cur[i] = 0;
    end else begin
      if (tick && (m_state == S_RUN || m_state == S_FS))
        for (int i = 0; i < NM; i++) m_cur[i] = slew_to(m_cur[i], m_tgt[i]);
      case (m_state)
        S_DIS: if (arm && !m_fault) nxt = S_ARM;
        S_ARM: begin
          if (!arm) nxt = S_DIS;
          else if (tick) begin
            m_arm_frames++;
            if (m_arm_frames == AF) nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (tick && !cv && (m_idle + 1 == TF)) begin
            nxt = S_FS;
            m_fault = 1'b1;
          end else if (!arm) nxt = S_FS;
        end
        S_FS: begin
          if (tick) begin
            all_zero = 1'b1;
            for (int i = 0; i < NM; i++) if (m_cur[i] != 0) all_zero = 1'b0;
            if (all_zero) nxt = S_DIS;
          end
        end
        default: ;
      endcase
    end
    if (m_state == S_DIS && !arm) m_fault = 1'b0;
    if (nxt == S_FS || (nxt == S_DIS && m_state != S_DIS)) begin
      for (int i = 0; i < NM; i++) m_tgt[i] = 0;
    end else if (cv && m_state != S_FS) begin
      for (int i = 0; i < NM; i++) m_tgt[i] = imin(ch_of(cmd, i), MC);
    end
    if (nxt != S_ARM) m_arm_frames = 0;
    if (nxt != S_RUN || cv) m_idle = 0;
    else if (tick && m_state == S_RUN) m_idle++;
    m_state = nxt;
  endtask

  task automatic compare_all();
    logic [63:0] exp_out;
    for (int i = 0; i < NM; i++) exp_out[16*i +: 16] = 16'(m_cur[i]);
    check_eq("state",     64'(state),    64'(m_state));
    check_eq("speed_oe",  64'(speed_oe), 64'(m_oe));
    check_eq("armed",     64'(armed),    64'(m_state == S_RUN));
    check_eq("fault",     64'(fault),    64'(m_fault));
    check_eq("speed_out", speed_out,     exp_out);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(arm_req, disarm_req, cmd_valid, cmd_speed);
    @(negedge clk);
    compare_all();
  endtask

  task automatic next_frame(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (speed_oe !== 1'b1 && n < 2 * FC);
    if (speed_oe !== 1'b1) check_eq("oe_wait", 64'(speed_oe), 64'(1));
  endtask

  task automatic send_cmd(input int c0, input int c1);
    cmd_valid = 1'b1;
    cmd_speed = '0;
    cmd_speed[15:0]  = 16'(c0);
    cmd_speed[31:16] = 16'(c1);
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_st[7];
    int exp_c0[7];
    exp_st = '{2, 2, 2, 3, 3, 3, 0};
    exp_c0 = '{250, 250, 250, 250, 150, 50, 0};
    rst_n = 1'b0; arm_req = 1'b0; disarm_req = 1'b0; cmd_valid = 1'b0; cmd_speed = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_state", 64'(state), 64'(0));
    check_eq("rst_oe",    64'(speed_oe), 64'(0));
    check_eq("rst_out",   speed_out, 64'(0));
    check_eq("rst_armed", 64'(armed), 64'(0));
    check_eq("rst_fault", 64'(fault), 64'(0));

    // Arming: three zero frames at a 10-cycle cadence, then RUN
    rst_n = 1'b1;
    arm_req = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      next_frame(ncyc);
      check_eq("oe_period", 64'(ncyc), 64'(FC));
      check_eq("arm_zero", speed_out, 64'(0));
      check_eq("arm_state", 64'(state), 64'((f == 3) ? S_RUN : S_ARM));
    end
    check_eq("armed_run", 64'(armed), 64'(1));

    // Slew and clamp ramp
    send_cmd(250, 60000);
    for (int k = 1; k <= 460; k++) begin
      next_frame(ncyc);
      if (k <= 4) check_eq("ch0_ramp", 64'(ch_of(speed_out, 0)), 64'(imin(250, 100 * k)));
      check_eq("ch1_clamp", 64'(ch_of(speed_out, 1)), 64'(imin(100 * k, MC)));
      send_cmd(250, 60000);
    end
    for (int k = 1; k <= 455; k++) begin
      next_frame(ncyc);
      send_cmd(250, 0);
    end
    check_eq("ch1_down", 64'(ch_of(speed_out, 1)), 64'(0));

    // Command timeout into FAILSAFE and ramp-down
    for (int f = 0; f < 7; f++) begin
      next_frame(ncyc);
      check_eq("to_state", 64'(state), 64'(exp_st[f]));
      check_eq("to_ch0", 64'(ch_of(speed_out, 0)), 64'(exp_c0[f]));
    end
    check_eq("to_fault", 64'(fault), 64'(1));
    next_frame(ncyc);
    next_frame(ncyc);
    check_eq("rearm_blocked", 64'(state), 64'(S_DIS));
    arm_req = 1'b0;
    cycle();
    check_eq("fault_clr", 64'(fault), 64'(0));
    arm_req = 1'b1;
    cycle();
    check_eq("rearm_state", 64'(state), 64'(S_ARM));

    // Command coinciding with tick takes effect one frame later
    for (int f = 0; f < 3; f++) next_frame(ncyc);
    check_eq("run_again", 64'(state), 64'(S_RUN));
    for (int w = 0; w < 2 * FC && m_phase != FC - 1; w++) cycle();
    send_cmd(250, 0);
    check_eq("tick_cmd_oe", 64'(speed_oe), 64'(1));
    check_eq("tick_cmd_out", 64'(ch_of(speed_out, 0)), 64'(0));
    for (int f = 1; f <= 3; f++) begin
      next_frame(ncyc);
      check_eq("tick_cmd_ch0", 64'(ch_of(speed_out, 0)), 64'(imin(250, 100 * f)));
      check_eq("tick_cmd_run", 64'(state), 64'(S_RUN));
    end

    // Disarm override at speed
    send_cmd(2000, 0);
    for (int f = 0; f < 20; f++) begin
      next_frame(ncyc);
      send_cmd(2000, 0);
    end
    check_eq("pre_disarm", 64'(ch_of(speed_out, 0)), 64'(2000));
    disarm_req = 1'b1;
    cycle();
    disarm_req = 1'b0;
    check_eq("disarm_state", 64'(state), 64'(S_DIS));
    check_eq("disarm_out", speed_out, 64'(0));
    check_eq("disarm_fault", 64'(fault), 64'(0));

    // Async reset in the middle of FAILSAFE
    cycle();
    for (int f = 0; f < 3; f++) next_frame(ncyc);
    for (int f = 0; f < 12; f++) begin
      send_cmd(1000, 0);
      next_frame(ncyc);
    end
    for (int f = 0; f < 8 && m_state != S_FS; f++) next_frame(ncyc);
    next_frame(ncyc);
    repeat (3) cycle();
    check_eq("pre_rst_state", 64'(state), 64'(S_FS));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_state", 64'(state), 64'(0));
    check_eq("arst_out",   speed_out, 64'(0));
    check_eq("arst_oe",    64'(speed_oe), 64'(0));
    check_eq("arst_armed", 64'(armed), 64'(0));
    check_eq("arst_fault", 64'(fault), 64'(0));
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;

    // Random traffic with varying command rates
    for (int ep = 0; ep < 12; ep++) begin
      int rate;
      rate = (ep % 3 == 0) ? 0 : ((ep % 3 == 1) ? 4 : 40);
      for (int c = 0; c < 500; c++) begin
        cmd_valid = (rate != 0) && ($urandom_range(rate - 1) == 0);
        for (int i = 0; i < NM; i++)
          cmd_speed[16*i +: 16] = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(1500));
        if ($urandom_range(199) == 0) arm_req = ~arm_req;
        disarm_req = ($urandom_range(399) == 0);
        rst_n = ($urandom_range(2999) != 0);
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
